tt_um_arko: RTL and testbench
=============================

// Module: tt_um_arko
//
// PURPOSE
// - Tiny Tapeout user tile: 8-bit accumulator ALU with registered result and flags.
// - Operand on ui_in, opcode/strobe on uio_in[4:0], accumulator on uo_out, flags on uio_out[7:5].
// - Top-level of the user project. The board harness drives the pins through a cocotb bench.
//
// PARAMETERS
// - none (all widths fixed by the Tiny Tapeout pin frame)
//
// PORTS
// clk      in   1  system clock; all state updates on rising edge
// rst_n    in   1  reset; one clock, reset asynchronous and active-low
// ena      in   1  tile enable; when 0 no operation executes (state holds)
// ui_in    in   8  operand A
// uo_out   out  8  accumulator ACC (registered)
// uio_in   in   8  [3:0] opcode, [4] execute strobe EXE, [7:5] ignored
// uio_out  out  8  [7] C carry/borrow, [6] Z zero, [5] N negative, [4:0] = 0
// uio_oe   out  8  constant 8'b1110_0000 (bits 7:5 outputs, 4:0 inputs)
//
// BEHAVIOUR
// - Reset (rst_n=0, async): ACC=8'h00, C=0; Z=1, N=0 follow from ACC; uio_out[4:0]=0.
// - Execute condition: ena=1 AND EXE=1 at a rising clk edge; otherwise ACC and C hold.
// - EXE is level-sensitive: held high, the op repeats every cycle (no edge detect).
// - Latency: one cycle; result on uo_out/flags immediately after the executing edge.
// - Opcodes (A=ui_in, 8-bit wrap on all results):
//   0 NOP  ACC,C hold            8 SHL  ACC=ACC<<1,  C=old ACC[7]
//   1 LOAD ACC=A,     C=0        9 SHR  ACC=ACC>>1 (logical), C=old ACC[0]
//   2 ADD  ACC=ACC+A, C=carry-out  A ROL  ACC={ACC[6:0],ACC[7]}, C=old ACC[7]
//   3 SUB  ACC=ACC-A, C=1 iff A>ACC (borrow)  B ROR  ACC={ACC[0],ACC[7:1]}, C=old ACC[0]
//   4 AND  ACC=ACC&A, C=0        C INC  ACC=ACC+1, C=1 iff old ACC=8'hFF
//   5 OR   ACC=ACC|A, C=0        D DEC  ACC=ACC-1, C=1 iff old ACC=8'h00
//   6 XOR  ACC=ACC^A, C=0        E CLR  ACC=8'h00, C=0
//   7 NOT  ACC=~ACC,  C=0        F SWAP ACC={ACC[3:0],ACC[7:4]}, C=0
// - Z = (ACC==0), N = ACC[7]; combinational from registered ACC (no extra latency).
// - Carry is not an input to ADD/SUB (no ADC/SBC).
// - ena=0 mid-sequence: state frozen, outputs keep driving current ACC/flags.
// - Reset asserted mid-operation: takes effect immediately, no pending op retained.
// - uio_in[7:5] and uio_in when ena=0 have no effect; no X propagation from unused pins.
//
// TESTING
// - Reset: rst_n=0 -> uo_out=00, uio_out=8'h40 (Z=1), uio_oe=8'hE0; release, no EXE -> unchanged.
// - LOAD 8'hF0 then ADD 8'h20 -> uo_out=10, C=1, Z=0, N=0; SUB 8'h11 -> uo_out=FF, C=1, N=1.
// - LOAD 8'h81; SHL -> 02, C=1; ROR -> 01, C=0; SHR -> 00, C=1, Z=1; DEC -> FF, C=1.
// - LOAD 8'h3C; XOR 8'hFF -> C3; SWAP -> 3C; NOT -> C3, N=1; CLR -> 00, Z=1.
// - EXE held with INC from 8'hFE: 3 edges -> FF, 00 (C=1,Z=1), 01 (C=0); ena=0 -> holds 01.
// - Assert rst_n async between edges during ADD stream -> uo_out=00 immediately, C=0.

Source files
------------

// File: rtl/tt_um_arko.sv
// Tiny Tapeout tile: 8-bit accumulator ALU with registered accumulator and carry.
// The Z and N flags are decoded directly from the registered accumulator.
module tt_um_arko (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_INC  = 4'hC,
        OP_DEC  = 4'hD,
        OP_CLR  = 4'hE,
        OP_SWAP = 4'hF
    } opcode_e;

    logic [7:0] accQ, accD;
    logic       carryQ, carryD;
    logic [8:0] sumWide;
    logic [8:0] diffWide;
    logic       execute;
    opcode_e    op;
    logic       unusedBits;

    assign op         = opcode_e'(uio_in[3:0]);
    assign execute    = ena & uio_in[4];
    assign unusedBits = &{1'b0, uio_in[7:5]};

    // Bit 8 of the widened subtraction is the borrow, set exactly when A > ACC.
    assign sumWide  = {1'b0, accQ} + {1'b0, ui_in};
    assign diffWide = {1'b0, accQ} - {1'b0, ui_in};

    always_comb begin
        accD   = accQ;
        carryD = carryQ;
        if (execute) begin
            case (op)
                OP_NOP:  begin accD = accQ;                    carryD = carryQ;          end
                OP_LOAD: begin accD = ui_in;                   carryD = 1'b0;            end
                OP_ADD:  begin accD = sumWide[7:0];            carryD = sumWide[8];      end
                OP_SUB:  begin accD = diffWide[7:0];           carryD = diffWide[8];     end
                OP_AND:  begin accD = accQ & ui_in;            carryD = 1'b0;            end
                OP_OR:   begin accD = accQ | ui_in;            carryD = 1'b0;            end
                OP_XOR:  begin accD = accQ ^ ui_in;            carryD = 1'b0;            end
                OP_NOT:  begin accD = ~accQ;                   carryD = 1'b0;            end
                OP_SHL:  begin accD = {accQ[6:0], 1'b0};       carryD = accQ[7];         end
                OP_SHR:  begin accD = {1'b0, accQ[7:1]};       carryD = accQ[0];         end
                OP_ROL:  begin accD = {accQ[6:0], accQ[7]};    carryD = accQ[7];         end
                OP_ROR:  begin accD = {accQ[0], accQ[7:1]};    carryD = accQ[0];         end
                OP_INC:  begin accD = accQ + 8'h01;            carryD = (accQ == 8'hFF); end
                OP_DEC:  begin accD = accQ - 8'h01;            carryD = (accQ == 8'h00); end
                OP_CLR:  begin accD = 8'h00;                   carryD = 1'b0;            end
                OP_SWAP: begin accD = {accQ[3:0], accQ[7:4]};  carryD = 1'b0;            end
                default: begin accD = accQ;                    carryD = carryQ;          end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accQ   <= 8'h00;
            carryQ <= 1'b0;
        end else begin
            accQ   <= accD;
            carryQ <= carryD;
        end
    end

    assign uo_out  = accQ;
    assign uio_out = {carryQ, (accQ == 8'h00), accQ[7], 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_arko.sv
// Scoreboard bench for tt_um_arko: directed ALU vectors queue their expected
// accumulator/flag bytes, and a negedge monitor pops and compares them.
module tb_tt_um_arko;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        string      name;
        logic [7:0] acc;
        logic [7:0] flags;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   failCount  = 0;

    localparam logic [3:0] NOP = 4'h0, LOAD = 4'h1, ADD = 4'h2, SUB = 4'h3,
                           AND = 4'h4, OR = 4'h5, XOR = 4'h6, NOT = 4'h7,
                           SHL = 4'h8, SHR = 4'h9, ROL = 4'hA, ROR = 4'hB,
                           INC = 4'hC, DEC = 4'hD, CLR = 4'hE, SWAP = 4'hF;

    tt_um_arko dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exe(input logic [3:0] op);
        return {3'b000, 1'b1, op};
    endfunction

    function automatic logic [7:0] flg(input logic c, input logic z, input logic n);
        return {c, z, n, 5'b0_0000};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] expAcc,
                               input logic [7:0] expFlags);
        checkCount++;
        if (uo_out !== expAcc || uio_out !== expFlags) begin
            failCount++;
            $display("[TB] FAIL %s: got uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
                     name, uo_out, uio_out, expAcc, expFlags);
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, then queues the expected result.
    task automatic applyStimulus(input string name, input logic en, input logic [7:0] uio,
                                 input logic [7:0] a, input logic [7:0] expAcc,
                                 input logic [7:0] expFlags);
        exp_t e;
        ena    = en;
        uio_in = uio;
        ui_in  = a;
        @(posedge clk);
        e.name  = name;
        e.acc   = expAcc;
        e.flags = expFlags;
        sb.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e.name, e.acc, e.flags);
            end
        end
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = exe(LOAD);
        #1;
        checkOutput("reset_state", 8'h00, flg(0, 1, 0));
        checkCount++;
        if (uio_oe !== 8'hE0) begin
            failCount++;
            $display("[TB] FAIL uio_oe: got %h, expected e0", uio_oe);
        end
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", 8'h00, flg(0, 1, 0));
        rst_n = 1'b1;

        applyStimulus("idle_no_exe", 1'b1, {3'b000, 1'b0, LOAD}, 8'hFF, 8'h00, flg(0, 1, 0));

        applyStimulus("load_f0",  1'b1, exe(LOAD), 8'hF0, 8'hF0, flg(0, 0, 1));
        applyStimulus("add_20",   1'b1, exe(ADD),  8'h20, 8'h10, flg(1, 0, 0));
        applyStimulus("sub_11",   1'b1, exe(SUB),  8'h11, 8'hFF, flg(1, 0, 1));

        applyStimulus("load_81",  1'b1, exe(LOAD), 8'h81, 8'h81, flg(0, 0, 1));
        applyStimulus("shl",      1'b1, exe(SHL),  8'h00, 8'h02, flg(1, 0, 0));
        applyStimulus("ror",      1'b1, exe(ROR),  8'h00, 8'h01, flg(0, 0, 0));
        applyStimulus("shr",      1'b1, exe(SHR),  8'h00, 8'h00, flg(1, 1, 0));
        applyStimulus("dec_00",   1'b1, exe(DEC),  8'h00, 8'hFF, flg(1, 0, 1));
        applyStimulus("nop_keepc",1'b1, exe(NOP),  8'h55, 8'hFF, flg(1, 0, 1));

        applyStimulus("load_3c",  1'b1, exe(LOAD), 8'h3C, 8'h3C, flg(0, 0, 0));
        applyStimulus("xor_ff",   1'b1, exe(XOR),  8'hFF, 8'hC3, flg(0, 0, 1));
        applyStimulus("swap",     1'b1, exe(SWAP), 8'h00, 8'h3C, flg(0, 0, 0));
        applyStimulus("not",      1'b1, exe(NOT),  8'h00, 8'hC3, flg(0, 0, 1));
        applyStimulus("clr",      1'b1, exe(CLR),  8'hAA, 8'h00, flg(0, 1, 0));

        applyStimulus("or_5a",    1'b1, exe(OR),   8'h5A, 8'h5A, flg(0, 0, 0));
        applyStimulus("and_0f",   1'b1, exe(AND),  8'h0F, 8'h0A, flg(0, 0, 0));
        applyStimulus("rol",      1'b1, exe(ROL),  8'h00, 8'h14, flg(0, 0, 0));
        applyStimulus("add_01",   1'b1, exe(ADD),  8'h01, 8'h15, flg(0, 0, 0));
        applyStimulus("sub_equal",1'b1, exe(SUB),  8'h15, 8'h00, flg(0, 1, 0));
        applyStimulus("upper_ign",1'b1, {3'b111, 1'b1, LOAD}, 8'h96, 8'h96, flg(0, 0, 1));
        applyStimulus("rol_msb",  1'b1, exe(ROL),  8'h00, 8'h2D, flg(1, 0, 0));

        applyStimulus("load_fe",  1'b1, exe(LOAD), 8'hFE, 8'hFE, flg(0, 0, 1));
        applyStimulus("inc_1",    1'b1, exe(INC),  8'h00, 8'hFF, flg(0, 0, 1));
        applyStimulus("inc_2",    1'b1, exe(INC),  8'h00, 8'h00, flg(1, 1, 0));
        applyStimulus("inc_3",    1'b1, exe(INC),  8'h00, 8'h01, flg(0, 0, 0));
        applyStimulus("ena0_a",   1'b0, exe(INC),  8'h77, 8'h01, flg(0, 0, 0));
        applyStimulus("ena0_b",   1'b0, exe(LOAD), 8'h77, 8'h01, flg(0, 0, 0));

        applyStimulus("load_10",  1'b1, exe(LOAD), 8'h10, 8'h10, flg(0, 0, 0));
        applyStimulus("stream_1", 1'b1, exe(ADD),  8'hF8, 8'h08, flg(1, 0, 0));
        applyStimulus("stream_2", 1'b1, exe(ADD),  8'h01, 8'h09, flg(0, 0, 0));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, flg(0, 1, 0));
        @(posedge clk);
        #1;
        checkOutput("reset_no_pending", 8'h00, flg(0, 1, 0));
        rst_n = 1'b1;
        applyStimulus("post_reset_add", 1'b1, exe(ADD), 8'h05, 8'h05, flg(0, 0, 0));

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checkCount++;
        if (sb.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
